// File: rtl/random_card_shoe.sv
// random_card_shoe: LFSR-driven card source over a finite multi-deck shoe.
// Deals ranks 1..13 without replacement until a shuffle refills the shoe.
// A draw tries up to MAX_TRIES random candidates, then falls back to a
// linear scan from rank 1 so that every draw finishes in bounded time.
// Optional feature macro: RANDOM_CARD_INFINITE_SHOE_EN (infinite shoe:
// counts never decrement, shoe never empties).
module random_card_shoe #(
   parameter int          NUM_DECKS = 1,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          MAX_TRIES = 32,
   localparam int         CL_W      = $clog2(52 * NUM_DECKS + 1)
) (
   input  logic            fast_clk,
   input  logic            rst_n,
   input  logic            req,
   input  logic            shuffle,
   output logic            card_valid,
   output logic [3:0]      new_card,
   output logic            busy,
   output logic            empty_err,
   output logic [CL_W-1:0] cards_left,
   output logic            shoe_empty
);

   localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
   localparam logic [CL_W-1:0]  FULL_LEFT = CL_W'(52 * NUM_DECKS);
   localparam logic [TRY_W-1:0] LAST_TRY  = TRY_W'(MAX_TRIES - 1);

   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_SCAN} state_t;

   state_t          r_state;
   logic [15:0]     r_lfsr;
   logic [TRY_W-1:0] r_try;
   logic [3:0]      r_scan;
   logic            r_card_valid;
   logic [3:0]      r_new_card;
   logic            r_busy;
   logic            r_empty_err;

   logic [4:0]      w_cand;
   logic            w_cand_ok;
   logic            w_scan_ok;
   logic            w_take;
   logic [3:0]      w_rank;

   // Candidate rank 1..16 straight from the low LFSR nibble.
   assign w_cand = {1'b0, r_lfsr[3:0]} + 5'd1;

`ifdef RANDOM_CARD_INFINITE_SHOE_EN
   // Every rank is always available, so any legal rank is accepted.
   assign w_cand_ok  = (w_cand <= 5'd13);
   assign w_scan_ok  = 1'b1;
   assign cards_left = FULL_LEFT;
   assign shoe_empty = 1'b0;
`else
   localparam int              CNT_W    = $clog2(4 * NUM_DECKS + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(4 * NUM_DECKS);

   logic [CNT_W-1:0] r_cnt [1:13];
   logic [CL_W-1:0]  r_cards_left;
   logic [15:0]      w_avail;

   // Availability mask indexed by rank; bits 0, 14 and 15 are never set.
   always_comb begin
      w_avail = '0;
      for (int r = 1; r <= 13; r++) begin
         w_avail[r] = (r_cnt[r] != '0);
      end
   end

   assign w_cand_ok  = (w_cand <= 5'd13) && w_avail[w_cand[3:0]];
   assign w_scan_ok  = w_avail[r_scan];
   assign cards_left = r_cards_left;
   assign shoe_empty = (r_cards_left == '0);

   // Shoe contents: refill on shuffle, otherwise consume the accepted card.
   always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 1; r <= 13; r++) r_cnt[r] <= FULL_CNT;
         r_cards_left <= FULL_LEFT;
      end else if (shuffle) begin
         for (int r = 1; r <= 13; r++) r_cnt[r] <= FULL_CNT;
         r_cards_left <= FULL_LEFT;
      end else if (w_take) begin
         r_cnt[w_rank] <= r_cnt[w_rank] - CNT_W'(1);
         r_cards_left  <= r_cards_left - CL_W'(1);
      end
   end
`endif

   // Accept decision for the current cycle: random candidate in DRAW,
   // scan pointer in SCAN.
   always_comb begin
      w_take = 1'b0;
      w_rank = 4'd0;
      case (r_state)
         S_DRAW: begin
            w_take = w_cand_ok;
            w_rank = w_cand[3:0];
         end
         S_SCAN: begin
            w_take = w_scan_ok;
            w_rank = r_scan;
         end
         default: ;
      endcase
   end

   // Galois LFSR, free-running in every state; shuffle leaves it alone.
   always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n) r_lfsr <= LFSR_SEED;
      else        r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   // Draw FSM with registered handshake outputs; shuffle overrides everything.
   always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_try        <= '0;
         r_scan       <= 4'd1;
         r_card_valid <= 1'b0;
         r_new_card   <= 4'd0;
         r_busy       <= 1'b0;
         r_empty_err  <= 1'b0;
      end else begin
         r_card_valid <= 1'b0;
         r_empty_err  <= 1'b0;
         if (shuffle) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (req) begin
                     if (shoe_empty) begin
                        r_empty_err <= 1'b1;
                     end else begin
                        r_state <= S_DRAW;
                        r_try   <= '0;
                        r_busy  <= 1'b1;
                     end
                  end
               end
               S_DRAW, S_SCAN: begin
                  if (w_take) begin
                     r_new_card   <= w_rank;
                     r_card_valid <= 1'b1;
                     r_state      <= S_IDLE;
                     r_busy       <= 1'b0;
                  end else if (r_state == S_SCAN) begin
                     r_scan <= r_scan + 4'd1;
                  end else if (r_try == LAST_TRY) begin
                     r_state <= S_SCAN;
                     r_scan  <= 4'd1;
                  end else begin
                     r_try <= r_try + TRY_W'(1);
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign card_valid = r_card_valid;
   assign new_card   = r_new_card;
   assign busy       = r_busy;
   assign empty_err  = r_empty_err;

endmodule

// File: tb/tb_random_card_shoe.sv
// Bench for random_card_shoe: two instances (1 deck / MAX_TRIES=2 and
// 8 decks / MAX_TRIES=32) checked against a rank-count shoe model.
module tb_random_card_shoe;

   localparam int OP_DRAW   = 0;
   localparam int OP_SHREQ  = 1;
   localparam int OP_SHDRAW = 2;

   typedef struct {
      int op;
      int d;
      int exp_left;
   } vec_t;

   logic       fast_clk = 1'b0;
   logic       rst_n    = 1'b0;
   logic       req      [2];
   logic       shuffle  [2];
   logic       cv       [2];
   logic [3:0] nc       [2];
   logic       bsy      [2];
   logic       eerr     [2];
   logic       se       [2];
   logic [5:0] cl_a;
   logic [8:0] cl_b;

   int n_chk  = 0;
   int n_pass = 0;
   int m_cnt  [2][14];
   int m_left [2];
   int tally  [16];
   logic [15:0] m_lfsr;
   vec_t tbl [11];

   always #5 fast_clk = ~fast_clk;

   random_card_shoe #(.NUM_DECKS(1), .LFSR_SEED(16'hACE1), .MAX_TRIES(2)) u_a (
      .fast_clk(fast_clk), .rst_n(rst_n), .req(req[0]), .shuffle(shuffle[0]),
      .card_valid(cv[0]), .new_card(nc[0]), .busy(bsy[0]), .empty_err(eerr[0]),
      .cards_left(cl_a), .shoe_empty(se[0]));

   random_card_shoe #(.NUM_DECKS(8), .LFSR_SEED(16'hACE1), .MAX_TRIES(32)) u_b (
      .fast_clk(fast_clk), .rst_n(rst_n), .req(req[1]), .shuffle(shuffle[1]),
      .card_valid(cv[1]), .new_card(nc[1]), .busy(bsy[1]), .empty_err(eerr[1]),
      .cards_left(cl_b), .shoe_empty(se[1]));

   // Polynomial x^16+x^14+x^13+x^11+1, right-shifting Galois form.
   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      logic [15:0] n;
      n = v >> 1;
      if (v[0]) n = n ^ 16'hB400;
      return n;
   endfunction

   // Reference LFSR: both instances share seed and reset, so one copy serves.
   always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= lfsr_step(m_lfsr);
   end

   function automatic int mt_of(input int d);
      return (d == 0) ? 2 : 32;
   endfunction

   function automatic int full_of(input int d);
      return (d == 0) ? 52 : 416;
   endfunction

   function automatic int left_of(input int d);
      return (d == 0) ? int'(cl_a) : int'(cl_b);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_fill(input int d);
      for (int r = 1; r <= 13; r++) m_cnt[d][r] = full_of(d) / 13;
      m_left[d] = full_of(d);
   endtask

   // Expected rank and latency (edges from the req-sampling edge) given the
   // LFSR value seen during the first DRAW cycle.
   task automatic predict(input int d, input logic [15:0] l0, output int rank, output int lat);
      logic [15:0] l;
      int c;
      l = l0;
      rank = 0;
      lat = -1;
      for (int k = 0; k < mt_of(d); k++) begin
         c = int'(l[3:0]) + 1;
         if (c <= 13 && m_cnt[d][c] > 0) begin
            rank = c;
            lat = 2 + k;
            return;
         end
         l = lfsr_step(l);
      end
      for (int r = 1; r <= 13; r++) begin
         if (m_cnt[d][r] > 0) begin
            rank = r;
            lat = 1 + mt_of(d) + r;
            return;
         end
      end
   endtask

   task automatic draw(input int d, output int rank);
      int er, el, lat;
      bit got;
      @(negedge fast_clk);
      req[d] = 1'b1;
      @(posedge fast_clk);
      #1;
      req[d] = 1'b0;
      chk("busy_in_draw", int'(bsy[d]), 1);
      predict(d, m_lfsr, er, el);
      got = 1'b0;
      lat = 1;
      while (!got && lat < 2 + mt_of(d) + 13 + 4) begin
         @(posedge fast_clk);
         #1;
         lat++;
         if (cv[d]) got = 1'b1;
      end
      chk("draw_latency", got ? lat : -1, el);
      chk("draw_rank", int'(nc[d]), er);
`ifndef RANDOM_CARD_INFINITE_SHOE_EN
      if (er > 0) begin
         m_cnt[d][er]--;
         m_left[d]--;
      end
`endif
      chk("cards_left", left_of(d), m_left[d]);
      chk("shoe_empty", int'(se[d]), int'(m_left[d] == 0));
      chk("busy_on_valid", int'(bsy[d]), 0);
      rank = int'(nc[d]);
      @(posedge fast_clk);
      #1;
      chk("valid_one_cycle", int'(cv[d]), 0);
      chk("card_held", int'(nc[d]), er);
   endtask

   task automatic shreq(input int d, input int exp_left);
      @(negedge fast_clk);
      req[d] = 1'b1;
      shuffle[d] = 1'b1;
      @(posedge fast_clk);
      #1;
      req[d] = 1'b0;
      shuffle[d] = 1'b0;
      model_fill(d);
      chk("shreq_no_valid", int'(cv[d]), 0);
      chk("shreq_idle", int'(bsy[d]), 0);
      chk("shreq_left", left_of(d), exp_left);
      @(posedge fast_clk);
      #1;
      chk("shreq_req_dropped", int'(bsy[d]), 0);
      chk("shreq_no_valid2", int'(cv[d]), 0);
   endtask

   task automatic shdraw(input int d, input int exp_left);
      @(negedge fast_clk);
      req[d] = 1'b1;
      @(posedge fast_clk);
      #1;
      req[d] = 1'b0;
      chk("shdraw_busy", int'(bsy[d]), 1);
      @(negedge fast_clk);
      shuffle[d] = 1'b1;
      @(posedge fast_clk);
      #1;
      shuffle[d] = 1'b0;
      model_fill(d);
      chk("shdraw_left", left_of(d), exp_left);
      chk("shdraw_idle", int'(bsy[d]), 0);
      chk("shdraw_no_valid", int'(cv[d]), 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge fast_clk);
         #1;
         chk("shdraw_aborted", int'(cv[d]) + int'(bsy[d]), 0);
      end
   endtask

   task automatic empty_req(input int d);
      @(negedge fast_clk);
      req[d] = 1'b1;
      @(posedge fast_clk);
      #1;
      req[d] = 1'b0;
      chk("empty_err_pulse", int'(eerr[d]), 1);
      chk("empty_no_valid", int'(cv[d]), 0);
      chk("empty_not_busy", int'(bsy[d]), 0);
      @(posedge fast_clk);
      #1;
      chk("empty_err_one_cycle", int'(eerr[d]), 0);
      chk("empty_no_valid2", int'(cv[d]), 0);
   endtask

   task automatic reset_checks(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk({tag, "_valid"}, int'(cv[d]), 0);
         chk({tag, "_card"}, int'(nc[d]), 0);
         chk({tag, "_busy"}, int'(bsy[d]), 0);
         chk({tag, "_err"}, int'(eerr[d]), 0);
         chk({tag, "_empty"}, int'(se[d]), 0);
         chk({tag, "_left"}, left_of(d), full_of(d));
      end
   endtask

   initial begin
      int rk;
      for (int d = 0; d < 2; d++) begin
         req[d] = 1'b0;
         shuffle[d] = 1'b0;
         model_fill(d);
      end
      repeat (3) @(negedge fast_clk);
      reset_checks("reset");
      rst_n = 1'b1;

`ifdef RANDOM_CARD_INFINITE_SHOE_EN
      for (int r = 0; r < 16; r++) tally[r] = 0;
      for (int i = 0; i < 1000; i++) begin
         draw(0, rk);
         tally[rk]++;
      end
      for (int r = 1; r <= 13; r++) chk("inf_rank_seen", int'(tally[r] > 0), 1);
      chk("inf_no_bad_rank", tally[0] + tally[14] + tally[15], 0);
`else
      tbl[0]  = '{OP_DRAW,   0, 51};
      tbl[1]  = '{OP_DRAW,   0, 50};
      tbl[2]  = '{OP_SHREQ,  0, 52};
      tbl[3]  = '{OP_DRAW,   0, 51};
      tbl[4]  = '{OP_SHDRAW, 0, 52};
      tbl[5]  = '{OP_DRAW,   1, 415};
      tbl[6]  = '{OP_DRAW,   1, 414};
      tbl[7]  = '{OP_SHDRAW, 1, 416};
      tbl[8]  = '{OP_DRAW,   1, 415};
      tbl[9]  = '{OP_SHREQ,  1, 416};
      tbl[10] = '{OP_DRAW,   0, 51};
      for (int i = 0; i < 11; i++) begin
         case (tbl[i].op)
            OP_DRAW: begin
               draw(tbl[i].d, rk);
               chk("tbl_left", left_of(tbl[i].d), tbl[i].exp_left);
               chk("tbl_rank_range", int'(rk >= 1 && rk <= 13), 1);
            end
            OP_SHREQ:  shreq(tbl[i].d, tbl[i].exp_left);
            default:   shdraw(tbl[i].d, tbl[i].exp_left);
         endcase
      end

      // One deck, randomly spaced requests, dealt to exhaustion.
      shreq(0, 52);
      for (int r = 0; r < 16; r++) tally[r] = 0;
      for (int i = 0; i < 52; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge fast_clk);
         draw(0, rk);
         tally[rk]++;
      end
      for (int r = 1; r <= 13; r++) chk("tally_1deck", tally[r], 4);
      chk("empty_after_52", int'(se[0]), 1);
      empty_req(0);

      // Eight decks dealt to exhaustion.
      for (int r = 0; r < 16; r++) tally[r] = 0;
      for (int i = 0; i < 416; i++) begin
         repeat ($urandom_range(0, 1)) @(negedge fast_clk);
         draw(1, rk);
         tally[rk]++;
      end
      for (int r = 1; r <= 13; r++) chk("tally_8deck", tally[r], 32);
      chk("left_8deck_zero", left_of(1), 0);
      empty_req(1);
      shreq(1, 416);
      shreq(0, 52);
      draw(0, rk);
`endif

      // Asynchronous reset in the middle of a draw.
      @(negedge fast_clk);
      req[1] = 1'b1;
      @(posedge fast_clk);
      #1;
      req[1] = 1'b0;
      chk("pre_reset_busy", int'(bsy[1]), 1);
      #2;
      rst_n = 1'b0;
      #1;
      reset_checks("async_reset");
      for (int d = 0; d < 2; d++) model_fill(d);
      @(negedge fast_clk);
      rst_n = 1'b1;
      draw(0, rk);
      draw(1, rk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
